// File: rtl/tree_sample_driver.sv
// rtl/tree_sample_driver.sv - host-side driver feeding byte-serial samples to the weather decision tree
module tree_sample_driver #(
  parameter int FEAT_W        = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  output logic [FEAT_W-1:0] tree_temp_max,
  output logic [FEAT_W-1:0] tree_temp_min,
  output logic [FEAT_W-1:0] tree_precipitation,
  output logic [FEAT_W-1:0] tree_wind,
  output logic              tree_rst,
  input  logic [2:0]        tree_class,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2:0]        m_class,
  output logic [CNT_W-1:0]  m_seq,
  output logic [CNT_W-1:0]  cnt_sunny,
  output logic [CNT_W-1:0]  cnt_rainy,
  output logic [CNT_W-1:0]  cnt_snowy,
  output logic [CNT_W-1:0]  cnt_invalid,
  output logic              busy
);

  if (SETTLE_CYCLES < 3) begin : g_settle_check
    $error("SETTLE_CYCLES must be at least 3");
  end

  localparam int SC_W = $clog2(SETTLE_CYCLES);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, TRST, SETTLE, OUTPUT} state_t;

  state_t            state, state_next;
  logic [1:0]        idx;
  logic [SC_W-1:0]   settle_cnt;
  logic [FEAT_W-1:0] stg_temp_max, stg_temp_min, stg_precipitation;
  logic              accept, capture, handshake;

  assign accept    = s_valid && s_ready;
  assign capture   = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
  assign handshake = (state == OUTPUT) && m_valid && m_ready;
  assign busy      = (state != COLLECT);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    tree_rst   = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid && idx == 2'd3) state_next = TRST;
      end
      TRST: begin
        tree_rst   = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = OUTPUT;
      end
      OUTPUT: begin
        if (m_valid && m_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Word 3 bypasses staging so all four features reach the tree on the same edge.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      idx                <= 2'd0;
      stg_temp_max       <= '0;
      stg_temp_min       <= '0;
      stg_precipitation  <= '0;
      tree_temp_max      <= '0;
      tree_temp_min      <= '0;
      tree_precipitation <= '0;
      tree_wind          <= '0;
    end else if (accept) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0: stg_temp_max      <= s_data;
        2'd1: stg_temp_min      <= s_data;
        2'd2: stg_precipitation <= s_data;
        default: begin
          tree_temp_max      <= stg_temp_max;
          tree_temp_min      <= stg_temp_min;
          tree_precipitation <= stg_precipitation;
          tree_wind          <= s_data;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (state == TRST) begin
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_class <= 3'b111;
      m_seq   <= '0;
    end else if (capture) begin
      m_valid <= 1'b1;
      m_class <= tree_class;
    end else if (handshake) begin
      m_valid <= 1'b0;
      m_seq   <= m_seq + 1'b1;
    end
  end

  // Tallies saturate so a long-running board never shows a wrapped count.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      cnt_sunny   <= '0;
      cnt_rainy   <= '0;
      cnt_snowy   <= '0;
      cnt_invalid <= '0;
    end else if (capture) begin
      case (tree_class)
        3'b000:  if (cnt_sunny   != '1) cnt_sunny   <= cnt_sunny   + 1'b1;
        3'b001:  if (cnt_rainy   != '1) cnt_rainy   <= cnt_rainy   + 1'b1;
        3'b110:  if (cnt_snowy   != '1) cnt_snowy   <= cnt_snowy   + 1'b1;
        default: if (cnt_invalid != '1) cnt_invalid <= cnt_invalid + 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_sample_driver.sv
// tb/tb_tree_sample_driver.sv - self-checking bench for tree_sample_driver (8-bit and 2-bit counter builds)
module tb_tree_sample_driver;

  localparam int FW = 5;

  logic          CLOCK_50 = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [FW-1:0] s_data = '0;
  logic          m_ready = 1'b0;
  logic [2:0]    tree_class;
  logic [2:0]    stub_cls = 3'b000;
  int            stub_age;

  logic          s_ready8, tree_rst8, m_valid8, busy8;
  logic [FW-1:0] tmx8, tmn8, prc8, wnd8;
  logic [2:0]    m_class8;
  logic [7:0]    m_seq8, sun8, rain8, snow8, inv8;

  logic          s_ready2, tree_rst2, m_valid2, busy2;
  logic [FW-1:0] tmx2, tmn2, prc2, wnd2;
  logic [2:0]    m_class2;
  logic [1:0]    m_seq2, sun2, rain2, snow2, inv2;

  int checks = 0;
  int errors = 0;
  int n_sun, n_rain, n_snow, n_inv, seq;
  logic [3:0][FW-1:0] exp_tree;
  logic [1:0] last_seq2;

  always #10 CLOCK_50 = ~CLOCK_50;

  tree_sample_driver u8 (
    .CLOCK_50(CLOCK_50), .rst(rst), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .tree_temp_max(tmx8), .tree_temp_min(tmn8), .tree_precipitation(prc8), .tree_wind(wnd8),
    .tree_rst(tree_rst8), .tree_class(tree_class), .m_valid(m_valid8), .m_ready(m_ready),
    .m_class(m_class8), .m_seq(m_seq8), .cnt_sunny(sun8), .cnt_rainy(rain8),
    .cnt_snowy(snow8), .cnt_invalid(inv8), .busy(busy8)
  );

  tree_sample_driver #(.CNT_W(2)) u2 (
    .CLOCK_50(CLOCK_50), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .tree_temp_max(tmx2), .tree_temp_min(tmn2), .tree_precipitation(prc2), .tree_wind(wnd2),
    .tree_rst(tree_rst2), .tree_class(tree_class), .m_valid(m_valid2), .m_ready(m_ready),
    .m_class(m_class2), .m_seq(m_seq2), .cnt_sunny(sun2), .cnt_rainy(rain2),
    .cnt_snowy(snow2), .cnt_invalid(inv2), .busy(busy2)
  );

  // Classifier stub: garbage right after restart, the intended class from two cycles on.
  always @(posedge CLOCK_50 or posedge rst) begin
    if (rst)                stub_age <= 0;
    else if (tree_rst8)     stub_age <= 0;
    else if (stub_age < 15) stub_age <= stub_age + 1;
  end
  assign tree_class = (stub_age >= 2) ? stub_cls : ~stub_cls;

  typedef struct {
    logic [3:0][FW-1:0] f;
    logic [2:0]         cls;
    int                 e_sun, e_rain, e_snow, e_inv, e_seq;
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input logic [2:0] cls, input int s, input int r,
                              input int n, input int i, input int q);
    vec_t v;
    v.f = {5'(d), 5'(c), 5'(b), 5'(a)};
    v.cls = cls;
    v.e_sun = s; v.e_rain = r; v.e_snow = n; v.e_inv = i; v.e_seq = q;
    return v;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [31:0] tree_vec8();
    return 32'({wnd8, prc8, tmn8, tmx8});
  endfunction

  function automatic logic [31:0] tree_vec2();
    return 32'({wnd2, prc2, tmn2, tmx2});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_tree8", tree_vec8(), 32'd0);
    chk("rst_tree2", tree_vec2(), 32'd0);
    chk("rst_tree_rst", 32'({tree_rst8, tree_rst2}), 32'd0);
    chk("rst_m_valid", 32'({m_valid8, m_valid2}), 32'd0);
    chk("rst_m_class", 32'({m_class8, m_class2}), 32'h3f);
    chk("rst_m_seq", 32'({m_seq8, m_seq2}), 32'd0);
    chk("rst_tallies8", 32'({sun8, rain8, snow8, inv8}), 32'd0);
    chk("rst_tallies2", 32'({sun2, rain2, snow2, inv2}), 32'd0);
    chk("rst_busy", 32'({busy8, busy2}), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge CLOCK_50);
    #3 rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #2 check_reset_vals();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rst = 1'b0;
    n_sun = 0; n_rain = 0; n_snow = 0; n_inv = 0; seq = 0;
    exp_tree = '0;
    #1 chk("s_ready_after_rst", 32'({s_ready8, s_ready2}), 32'd3);
    @(negedge CLOCK_50);
  endtask

  task automatic send_word(input logic [FW-1:0] d, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data  = FW'($urandom);
      @(negedge CLOCK_50);
    end
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready8 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 50) chk("s_ready_timeout", 32'(s_ready8), 32'd1);
    @(negedge CLOCK_50);
    s_valid = 1'b0;
  endtask

  task automatic check_model_tallies();
    chk("sun8", 32'(sun8), 32'(sat(n_sun, 8)));
    chk("rain8", 32'(rain8), 32'(sat(n_rain, 8)));
    chk("snow8", 32'(snow8), 32'(sat(n_snow, 8)));
    chk("inv8", 32'(inv8), 32'(sat(n_inv, 8)));
    chk("sun2", 32'(sun2), 32'(sat(n_sun, 2)));
    chk("rain2", 32'(rain2), 32'(sat(n_rain, 2)));
    chk("snow2", 32'(snow2), 32'(sat(n_snow, 2)));
    chk("inv2", 32'(inv2), 32'(sat(n_inv, 2)));
  endtask

  task automatic run_sample(input logic [3:0][FW-1:0] f, input logic [2:0] cls,
                            input logic [3:0][2:0] gaps, input int hold, input bit offer);
    logic [4:0] mv;
    logic       rr;
    bit         stable;
    stub_cls = cls;
    for (int i = 0; i < 4; i++) begin
      send_word(f[i], int'(gaps[i]));
      if (i < 3) chk("tree_hold_collect", tree_vec8(), 32'(exp_tree));
    end
    chk("tree_rst_on", 32'({tree_rst8, tree_rst2}), 32'd3);
    chk("tree_load8", tree_vec8(), 32'(f));
    chk("tree_load2", tree_vec2(), 32'(f));
    chk("trst_busy_sready", 32'({busy8, s_ready8}), 32'b10);
    exp_tree = f;
    s_valid = offer;
    s_data  = FW'($urandom);
    mv = '0;
    rr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK_50);
      mv[k] = m_valid8;
      rr = rr | tree_rst8;
    end
    chk("m_valid_latency", 32'(mv), 32'b10000);
    chk("tree_rst_width", 32'(rr), 32'd0);
    chk("m_class8", 32'(m_class8), 32'(cls));
    chk("m_class2", 32'(m_class2), 32'(cls));
    chk("m_seq8", 32'(m_seq8), 32'(seq % 256));
    chk("m_seq2", 32'(m_seq2), 32'(seq % 4));
    chk("tree_stable_settle", tree_vec8(), 32'(f));
    case (cls)
      3'b000:  n_sun++;
      3'b001:  n_rain++;
      3'b110:  n_snow++;
      default: n_inv++;
    endcase
    check_model_tallies();
    last_seq2 = m_seq2;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge CLOCK_50);
      if (!(m_valid8 && m_valid2 && m_class8 == cls && m_seq8 == 8'(seq) && !s_ready8 && busy8))
        stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    m_ready = 1'b1;
    @(negedge CLOCK_50);
    m_ready = 1'b0;
    s_valid = 1'b0;
    seq++;
    chk("after_hs_valid", 32'({m_valid8, m_valid2}), 32'd0);
    chk("after_hs_ready_busy", 32'({s_ready8, busy8}), 32'b10);
    chk("after_hs_seq8", 32'(m_seq8), 32'(seq % 256));
    chk("after_hs_seq2", 32'(m_seq2), 32'(seq % 4));
  endtask

  vec_t tbl[6];
  int   sat_exp[5] = '{1, 2, 3, 3, 3};
  int   seq_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [3:0][FW-1:0] f;
    logic [2:0] cls;
    logic [3:0][2:0] gaps;

    tbl[0] = mk(10, 0, 2, 4, 3'b110, 0, 0, 1, 0, 0);
    tbl[1] = mk(3, 1, 7, 9, 3'b011, 0, 0, 1, 1, 1);
    tbl[2] = mk(31, 0, 0, 31, 3'b000, 1, 0, 1, 1, 2);
    tbl[3] = mk(5, 5, 5, 5, 3'b001, 1, 1, 1, 1, 3);
    tbl[4] = mk(1, 2, 3, 4, 3'b111, 1, 1, 1, 2, 4);
    tbl[5] = mk(0, 0, 0, 0, 3'b010, 1, 1, 1, 3, 5);

    apply_reset();

    for (int i = 0; i < 6; i++) begin
      run_sample(tbl[i].f, tbl[i].cls, '0, 0, 1'b0);
      chk("tbl_tallies8", 32'({sun8, rain8, snow8, inv8}),
          32'({8'(tbl[i].e_sun), 8'(tbl[i].e_rain), 8'(tbl[i].e_snow), 8'(tbl[i].e_inv)}));
      chk("tbl_seq8", 32'(m_seq8), 32'(tbl[i].e_seq + 1));
    end

    // Back-pressure with a word offered while the result is stalled.
    run_sample({5'd7, 5'd6, 5'd5, 5'd4}, 3'b001, '0, 20, 1'b1);

    // Gapped input: s_valid pattern 1,0,0,1,0,1,1.
    gaps = {3'd0, 3'd1, 3'd2, 3'd0};
    run_sample({5'd17, 5'd13, 5'd11, 5'd9}, 3'b110, gaps, 0, 1'b0);

    // Reset after two words of a sample.
    send_word(5'd21, 0);
    send_word(5'd22, 0);
    apply_reset();
    run_sample({5'd3, 5'd2, 5'd1, 5'd30}, 3'b011, '0, 0, 1'b0);
    run_sample({5'd8, 5'd8, 5'd8, 5'd8}, 3'b000, '0, 2, 1'b0);

    // Reset while the tree is settling.
    stub_cls = 3'b001;
    for (int i = 0; i < 4; i++) send_word(5'(i + 1), 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    apply_reset();
    run_sample({5'd12, 5'd14, 5'd16, 5'd18}, 3'b001, '0, 0, 1'b0);

    // Saturation and sequence wrap on the 2-bit build.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_sample(20'($urandom), 3'b000, '0, 0, 1'b0);
      chk("sat_sunny2", 32'(sun2), 32'(sat_exp[i]));
      chk("seq_wrap2", 32'(last_seq2), 32'(seq_exp[i]));
    end

    // Randomized traffic against the counting model.
    for (int i = 0; i < 40; i++) begin
      f = 20'($urandom);
      case ($urandom_range(0, 3))
        0:       cls = 3'b000;
        1:       cls = 3'b001;
        2:       cls = 3'b110;
        default: cls = 3'($urandom);
      endcase
      for (int g = 0; g < 4; g++) gaps[g] = 3'($urandom_range(0, 3));
      run_sample(f, cls, gaps, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tree_sample_driver.md
Name: tree_sample_driver

Overview:
- Host-side counterpart of the weather decision-tree classifier.
- Accepts a byte-serial stream of feature words (temp_max, temp_min, precipitation, wind) over valid/ready.
- For each sample: presents the four features to the tree in parallel, restarts the tree from its root, waits a fixed settle time, then captures the 3-bit class code.
- Returns the class code over a valid/ready result port and keeps per-class tallies for the board display.

Parameters:
- FEAT_W, 5: width of each feature word and of each tree feature output.
- SETTLE_CYCLES, 4: cycles between the tree restart pulse and class capture. Legal minimum is 3; elaboration fails below 3.
- CNT_W, 8: width of m_seq and of each class tally counter.

Ports:
- CLOCK_50 input 1: system clock.
- rst input 1: asynchronous, active-high reset.
- s_valid input 1: feature word valid.
- s_ready output 1: driver can accept a feature word.
- s_data input FEAT_W: feature word. Order per sample is temp_max, temp_min, precipitation, wind.
- tree_temp_max output FEAT_W: feature to classifier.
- tree_temp_min output FEAT_W: feature to classifier.
- tree_precipitation output FEAT_W: feature to classifier.
- tree_wind output FEAT_W: feature to classifier.
- tree_rst output 1: one-cycle restart pulse to classifier.
- tree_class input 3: class code from classifier.
- m_valid output 1: result valid.
- m_ready input 1: result consumer ready.
- m_class output 3: captured class code.
- m_seq output CNT_W: index of the sample whose result is on m_class.
- cnt_sunny output CNT_W: class tally.
- cnt_rainy output CNT_W: class tally.
- cnt_snowy output CNT_W: class tally.
- cnt_invalid output CNT_W: class tally.
- busy output 1: high in every state except COLLECT.

Behaviour:
- Class codes: 000 sunny, 001 rainy, 110 snowy. Every other code is invalid. m_class passes the raw code through unchanged.
- States:
  - COLLECT, reset state.
  - TRST.
  - SETTLE.
  - OUTPUT.
- COLLECT:
  - s_ready=1.
  - A word is accepted when s_valid&&s_ready at a rising edge. It goes into staging register[idx], and the 2-bit idx then increments.
  - On acceptance of word 3: all four staging values (including the word just accepted) are copied to the tree_* outputs on the same edge, idx returns to 0, and the FSM goes to TRST.
- TRST:
  - tree_rst=1 for exactly this one cycle; s_ready=0.
  - Next state is SETTLE with settle counter=0.
- SETTLE:
  - Counter increments each cycle.
  - On the edge ending the cycle where counter==SETTLE_CYCLES-1: m_class<=tree_class, the matching tally updates, m_valid<=1, and the FSM goes to OUTPUT.
- OUTPUT:
  - m_valid, m_class and m_seq are held stable until m_valid&&m_ready.
  - On that handshake: m_valid<=0, m_seq<=m_seq+1 (wraps modulo 2^CNT_W), FSM goes to COLLECT.
  - s_ready=0 throughout OUTPUT.
- Latency: word 3 accepted at edge T; tree_rst high during cycle T..T+1; m_valid first high after edge T+1+SETTLE_CYCLES. Default setting: 5 edges after the final accept.
- tree_* outputs hold the current sample from the word-3 edge until the next sample's word-3 edge. They never change during TRST, SETTLE or OUTPUT.
- Tallies saturate at 2^CNT_W-1 and do not wrap. Exactly one tally changes per sample.
- Back-to-back operation: the first word of the next sample can be accepted on the edge after the OUTPUT handshake, i.e. the first cycle back in COLLECT.
- s_valid during TRST, SETTLE or OUTPUT is ignored. s_ready=0 there, so the source must hold the word.
- Reset (async, any state, including mid-sample):
  - State COLLECT, idx=0, staging and tree_* = 0, tree_rst=0.
  - s_ready=1 once rst deasserts; m_valid=0, m_class=3'b111.
  - m_seq=0, all tallies=0, busy=0.
  - A partially collected sample is discarded.
  - The classifier is assumed to share the system rst; tree_rst is not driven during reset.
- tree_class is sampled only on the capture edge. Its value at other times is don't-care.

Test Plan:
- Single sample: reset; send 10, 0, 2, 4 with s_valid held high; stub returns 110 two cycles after tree_rst. Expect tree_rst high exactly 1 cycle, m_valid 5 edges after the wind accept, m_class=110, m_seq=0, cnt_snowy=1, other tallies 0.
- Back-pressure: hold m_ready=0 for 20 cycles after m_valid. Expect m_valid/m_class/m_seq stable, s_ready=0, and a word offered meanwhile not accepted. Release m_ready: handshake, m_seq=1, s_ready=1 on the next cycle.
- Gapped input: s_valid toggles 1,0,0,1,0,1,1 across four words. Expect exactly four accepts, features mapped in order, tree_* unchanged until the fourth accept.
- Invalid and sequence: stub returns 011, then 000, then 001 over three samples. Expect m_class echoes 011, 000, 001; cnt_invalid=1, cnt_sunny=1, cnt_rainy=1; m_seq 0, 1, 2.
- Reset mid-operation: assert rst after 2 words, and separately during SETTLE. Expect immediate return to COLLECT, all outputs at reset values, no tally change. The next 4 words form a fresh sample with m_seq=0.
- Saturation (CNT_W=2): five sunny samples. Expect cnt_sunny 1, 2, 3, 3, 3; m_seq wraps 0, 1, 2, 3, 0.
